// File: rtl/alu_pkg.sv
// Shared ALU definitions: FSM states and op encodings
// for the iterative adder/subtractor.
package alu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } add_state_t;

  localparam logic ALU_OP_ADD = 1'b0;
  localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/cla_slice.sv
// Combinational SLICE-bit carry-lookahead adder slice.
// Produces sum, carry out and the carry into its top bit.
module cla_slice #(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout,
  output logic             c_msb
);

  logic [SLICE-1:0] w_g;
  logic [SLICE-1:0] w_p;
  logic [SLICE:0]   w_c;

  assign w_g = a & b;
  assign w_p = a ^ b;

  // c[i+1] = G[i:0] | P[i:0]&cin, flattened per bit
  always_comb begin
    logic t;
    logic pp;
    t      = 1'b0;
    pp     = 1'b0;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE; i++) begin
      t  = w_g[i];
      pp = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        t  = t | (pp & w_g[j]);
        pp = pp & w_p[j];
      end
      w_c[i+1] = t | (pp & cin);
    end
  end

  assign s     = w_p ^ w_c[SLICE-1:0];
  assign cout  = w_c[SLICE];
  assign c_msb = w_c[SLICE-1];

endmodule

// File: rtl/add_sub_iter.sv
// Iterative add/sub: one lookahead slice per cycle,
// LSB first, carry registered between slices.
module add_sub_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW =
    (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] K_LAST =
    CW'(NSLICE - 1);

  add_state_t       r_state;
  add_state_t       w_nxt;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [SLICE-1:0] w_sa;
  logic [SLICE-1:0] w_sb;
  logic [SLICE-1:0] w_s;
  logic             w_cout;
  logic             w_cmsb;
  logic             w_last;
  logic             w_take;
  logic [WIDTH-1:0] w_acc;

  assign w_sa   = r_a[int'(r_k)*SLICE +: SLICE];
  assign w_sb   = r_b[int'(r_k)*SLICE +: SLICE];
  assign w_last = (r_k == K_LAST);

  cla_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .a     (w_sa),
    .b     (w_sb),
    .cin   (r_c),
    .s     (w_s),
    .cout  (w_cout),
    .c_msb (w_cmsb)
  );

  always_comb begin
    w_acc = r_acc;
    w_acc[int'(r_k)*SLICE +: SLICE] = w_s;
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign w_take    = in_valid && in_ready;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_take)    w_nxt = ST_CALC;
      ST_CALC: if (w_last)    w_nxt = ST_DONE;
      ST_DONE: if (out_ready) w_nxt = ST_IDLE;
      default:                w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k    <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_acc  <= '0;
      r_res  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (w_take) begin
        r_a <= a;
        r_b <= (sub == ALU_OP_SUB) ? ~b : b;
        r_c <= (sub == ALU_OP_SUB) ? 1'b1 : cin;
        r_k <= '0;
      end
    end else if (r_state == ST_CALC) begin
      r_acc <= w_acc;
      r_c   <= w_cout;
      if (w_last) begin
        r_res  <= w_acc;
        r_cout <= w_cout;
        r_ovf  <= w_cmsb ^ w_cout;
        r_zero <= (w_acc == '0);
      end else begin
        r_k <= r_k + CW'(1);
      end
    end
  end

  assign res  = r_res;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_add_sub_iter.sv
// Bench for add_sub_iter in three configs:
// W8/S8, W32/S4, W64/S16.
module tb_add_sub_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  int          cfg;

  int checks = 0;
  int errors = 0;

  int wid [3] = '{8, 32, 64};
  int nsl [3] = '{1, 8, 4};

  always #5 clk = ~clk;

  logic iv0, iv1, iv2, or0, or1, or2;
  assign iv0 = in_valid && (cfg == 0);
  assign iv1 = in_valid && (cfg == 1);
  assign iv2 = in_valid && (cfg == 2);
  assign or0 = out_ready && (cfg == 0);
  assign or1 = out_ready && (cfg == 1);
  assign or2 = out_ready && (cfg == 2);

  logic        rd0, rd1, rd2, vl0, vl1, vl2;
  logic        co0, co1, co2, ov0, ov1, ov2;
  logic        z0, z1, z2;
  logic [7:0]  rs0;
  logic [31:0] rs1;
  logic [63:0] rs2;

  add_sub_iter #(.WIDTH(8), .SLICE(8)) u_w8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv0), .in_ready(rd0),
    .a(a[7:0]), .b(b[7:0]),
    .cin(cin), .sub(sub),
    .out_valid(vl0), .out_ready(or0),
    .res(rs0), .cout(co0), .ovf(ov0), .zero(z0)
  );

  add_sub_iter #(.WIDTH(32), .SLICE(4)) u_w32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv1), .in_ready(rd1),
    .a(a[31:0]), .b(b[31:0]),
    .cin(cin), .sub(sub),
    .out_valid(vl1), .out_ready(or1),
    .res(rs1), .cout(co1), .ovf(ov1), .zero(z1)
  );

  add_sub_iter #(.WIDTH(64), .SLICE(16)) u_w64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv2), .in_ready(rd2),
    .a(a), .b(b),
    .cin(cin), .sub(sub),
    .out_valid(vl2), .out_ready(or2),
    .res(rs2), .cout(co2), .ovf(ov2), .zero(z2)
  );

  logic        c_rdy, c_vld, c_co, c_ov, c_z;
  logic [63:0] c_res;

  always_comb begin
    c_rdy = rd0; c_vld = vl0; c_co = co0;
    c_ov  = ov0; c_z   = z0;
    c_res = {56'd0, rs0};
    if (cfg == 1) begin
      c_rdy = rd1; c_vld = vl1; c_co = co1;
      c_ov  = ov1; c_z   = z1;
      c_res = {32'd0, rs1};
    end else if (cfg == 2) begin
      c_rdy = rd2; c_vld = vl2; c_co = co2;
      c_ov  = ov2; c_z   = z2;
      c_res = rs2;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cfg=%0d got=%h want=%h",
               nm, cfg, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on W bits.
  task automatic model(input int w,
                       input logic [63:0] x, y,
                       input logic ci, sb,
                       output logic [63:0] r,
                       output logic co, ov, z);
    logic [64:0] m, xs, ys, s;
    m  = (65'd1 << w) - 65'd1;
    xs = {1'b0, x} & m;
    ys = {1'b0, y} & m;
    if (sb) begin
      s  = (xs - ys) & m;
      co = (xs >= ys);
    end else begin
      s  = xs + ys + {64'd0, ci};
      co = s[w];
    end
    r = s[63:0] & m[63:0];
    if (sb)
      ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
    else
      ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
    z = (r == 64'd0);
  endtask

  task automatic drain();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("drain", {62'd0, c_vld, c_rdy}, 64'd1);
  endtask

  task automatic wait_vld(output int lat);
    lat = 0;
    while (!c_vld && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic exec(input int c,
                      input logic [63:0] x, y,
                      input logic ci, sb,
                      output logic [63:0] r,
                      output logic co, ov, z,
                      output int lat);
    @(negedge clk);
    cfg = c; a = x; b = y; cin = ci; sub = sb;
    in_valid = 1'b1;
    #1 chk("in_ready", {63'd0, c_rdy}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    a   = {$urandom, $urandom};
    b   = {$urandom, $urandom};
    cin = ~ci;
    sub = ~sb;
    wait_vld(lat);
    r = c_res; co = c_co; ov = c_ov; z = c_z;
    drain();
  endtask

  task automatic cmp_all(input int lat,
                         input logic [63:0] r, er,
                         input logic co, eco,
                         input logic ov, eov,
                         input logic z, ez);
    chk("latency", 64'(lat), 64'(nsl[cfg]));
    chk("res", r, er);
    chk("cout", {63'd0, co}, {63'd0, eco});
    chk("ovf", {63'd0, ov}, {63'd0, eov});
    chk("zero", {63'd0, z}, {63'd0, ez});
  endtask

  typedef struct {
    int          c;
    logic [63:0] x, y;
    logic        ci, sb;
    logic [63:0] er;
    logic        eco, eov, ez;
  } vec_t;

  vec_t tbl [8];

  logic [63:0] r, er;
  logic        co, ov, z, eco, eov, ez;
  int          lat;

  function automatic logic [63:0] rnd(int w);
    logic [63:0] v;
    int          k;
    k = int'($urandom_range(0, 7));
    v = {$urandom, $urandom};
    if (k == 0) v = '0;
    if (k == 1) v = '1;
    if (k == 2) v = 64'd1 << (w - 1);
    return v;
  endfunction

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    cfg   = 0;
    rst_n = 1'b0;
    #1 chk("rst_rdy_low", {63'd0, rd1}, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    for (int c = 0; c < 3; c++) begin
      cfg = c;
      #1;
      chk("rst_vld", {63'd0, c_vld}, 64'd0);
      chk("rst_rdy", {63'd0, c_rdy}, 64'd1);
      chk("rst_res", c_res, 64'd0);
      chk("rst_flags", {61'd0, c_co, c_ov, c_z}, 64'd0);
    end

    tbl[0] = '{1, 64'hFFFF_FFFF, 64'h1, 0, 0,
               64'h0, 1, 0, 1};
    tbl[1] = '{1, 64'h8000_0000, 64'h1, 0, 1,
               64'h7FFF_FFFF, 1, 1, 0};
    tbl[2] = '{1, 64'h0, 64'h1, 0, 1,
               64'hFFFF_FFFF, 0, 0, 0};
    tbl[3] = '{1, 64'h7FFF_FFFF, 64'h0, 1, 0,
               64'h8000_0000, 0, 1, 0};
    tbl[4] = '{1, 64'h5, 64'h5, 1, 1,
               64'h0, 1, 0, 1};
    tbl[5] = '{1, 64'h1234_5678, 64'h1111_1111, 1, 0,
               64'h2345_678A, 0, 0, 0};
    tbl[6] = '{0, 64'h80, 64'h80, 0, 0,
               64'h0, 1, 1, 1};
    tbl[7] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0,
               64'h0, 1, 0, 1};

    for (int i = 0; i < 8; i++) begin
      exec(tbl[i].c, tbl[i].x, tbl[i].y,
           tbl[i].ci, tbl[i].sb,
           r, co, ov, z, lat);
      cmp_all(lat, r, tbl[i].er, co, tbl[i].eco,
              ov, tbl[i].eov, z, tbl[i].ez);
    end

    // Backpressure: hold DONE while a new op waits
    @(negedge clk);
    cfg = 1; a = 64'hF0; b = 64'h10;
    cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 a = 64'd5; b = 64'd6;
    wait_vld(lat);
    chk("bp_latency", 64'(lat), 64'd8);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_res", c_res, 64'h100);
      chk("bp_hold", {62'd0, c_vld, c_rdy}, 64'd2);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("bp_idle", {62'd0, c_vld, c_rdy}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("bp_take", {63'd0, c_rdy}, 64'd0);
    wait_vld(lat);
    chk("bp2_latency", 64'(lat), 64'd8);
    chk("bp2_res", c_res, 64'd11);
    drain();

    // Reset while slice counter is at 3
    @(negedge clk);
    cfg = 1; a = 64'hDEAD; b = 64'h1111;
    sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_vld", {63'd0, c_vld}, 64'd0);
    chk("abort_rdy", {63'd0, c_rdy}, 64'd1);
    chk("abort_res", c_res, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    exec(1, 64'd1, 64'd2, 1'b0, 1'b0,
         r, co, ov, z, lat);
    cmp_all(lat, r, 64'd3, co, 1'b0,
            ov, 1'b0, z, 1'b0);

    for (int c = 0; c < 3; c += 2) begin
      for (int n = 0; n < 1000; n++) begin
        logic [63:0] x, y;
        logic        ci, sb;
        x  = rnd(wid[c]);
        y  = rnd(wid[c]);
        ci = 1'($urandom);
        sb = 1'($urandom);
        model(wid[c], x, y, ci, sb, er, eco, eov, ez);
        exec(c, x, y, ci, sb, r, co, ov, z, lat);
        cmp_all(lat, r, er, co, eco, ov, eov, z, ez);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
